// File: rtl/scan_sched_pkg.sv
// Shared types and elaboration-time geometry helpers for the cascade-classifier scan scheduler.
package scan_sched_pkg;

  localparam int POS_XY_W   = 16;
  localparam int POS_S_W    = 8;
  localparam int MAX_SCALES = 32;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [POS_S_W-1:0]  scale;
    logic [POS_XY_W-1:0] y;
    logic [POS_XY_W-1:0] x;
  } win_pos_t;

  function automatic int scaled_dim(input int dim, input int s);
    int d;
    d = dim;
    for (int i = 0; i < MAX_SCALES; i++) begin
      if (i < s) d = (d * 4) / 5;
    end
    return d;
  endfunction

  function automatic logic scale_valid(input int iw, input int ih, input int fw, input int fh,
                                       input int s);
    return (scaled_dim(iw, s) >= fw) && (scaled_dim(ih, s) >= fh);
  endfunction

  // Returns sn when no scale can hold a window.
  function automatic int first_valid_scale(input int iw, input int ih, input int fw, input int fh,
                                           input int sn);
    int r;
    r = sn;
    for (int s = sn - 1; s >= 0; s--) begin
      if (scale_valid(iw, ih, fw, fh, s)) r = s;
    end
    return r;
  endfunction

  function automatic int window_count(input int iw, input int ih, input int fw, input int fh,
                                      input int sn, input int step);
    int n;
    n = 0;
    for (int s = 0; s < sn; s++) begin
      if (scale_valid(iw, ih, fw, fh, s))
        n += ((scaled_dim(iw, s) - fw) / step + 1) * ((scaled_dim(ih, s) - fh) / step + 1);
    end
    return n;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/pos_fifo.sv
// Show-ahead synchronous FIFO holding the positions of windows issued but not yet retired.
module pos_fifo
  import scan_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  win_pos_t    wdata_i,
  input  logic        pop_i,
  output win_pos_t    rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  win_pos_t      mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/scan_scheduler.sv
// Frame scan controller: walks every window position over all valid scales, bounds windows in
// flight, pairs in-order classifier verdicts with positions and reports detections per frame.
//
// state | meaning
// IDLE  | waiting for a loaded frame
// SCAN  | issuing window commands
// DRAIN | all windows issued, waiting for verdicts and the last detection
// DONE  | presenting the frame's detection count
module scan_scheduler
  import scan_sched_pkg::*;
#(
  parameter  int IMG_WIDTH      = 45,
  parameter  int IMG_HEIGHT     = 45,
  parameter  int FEATURE_WIDTH  = 25,
  parameter  int FEATURE_HEIGHT = 25,
  parameter  int SCALE_NUM      = 2,
  parameter  int STEP           = 1,
  parameter  int MAX_INFLIGHT   = 4,
  localparam int W_X   = $clog2(IMG_WIDTH),
  localparam int W_Y   = $clog2(IMG_HEIGHT),
  localparam int W_S   = max1($clog2(SCALE_NUM)),
  localparam int W_CNT = max1($clog2(window_count(IMG_WIDTH, IMG_HEIGHT, FEATURE_WIDTH,
                                                  FEATURE_HEIGHT, SCALE_NUM, STEP) + 1))
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  output logic             win_valid_o,
  input  logic             win_ready_i,
  output logic [W_X-1:0]   win_x_o,
  output logic [W_Y-1:0]   win_y_o,
  output logic [W_S-1:0]   win_scale_o,
  output logic             win_last_o,
  input  logic             result_valid_i,
  output logic             result_ready_o,
  input  logic             result_i,
  output logic             detect_valid_o,
  input  logic             detect_ready_i,
  output logic [W_X-1:0]   detect_x_o,
  output logic [W_Y-1:0]   detect_y_o,
  output logic [W_S-1:0]   detect_scale_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [W_CNT-1:0] done_count_o
);

  localparam int FIRST_SCALE = first_valid_scale(IMG_WIDTH, IMG_HEIGHT, FEATURE_WIDTH,
                                                 FEATURE_HEIGHT, SCALE_NUM);
  localparam logic ANY_VALID = (FIRST_SCALE < SCALE_NUM);
  localparam logic [W_S-1:0] FIRST_S = ANY_VALID ? W_S'(FIRST_SCALE) : '0;
  localparam logic [W_X-1:0] STEP_X  = W_X'(STEP);
  localparam logic [W_Y-1:0] STEP_Y  = W_Y'(STEP);
  localparam int FAW = $clog2(MAX_INFLIGHT);

  state_t           state_q, state_d;
  logic [W_X-1:0]   x_q, x_d;
  logic [W_Y-1:0]   y_q, y_d;
  logic [W_S-1:0]   s_q, s_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             det_valid_q, det_valid_d;
  logic [W_X-1:0]   det_x_q, det_x_d;
  logic [W_Y-1:0]   det_y_q, det_y_d;
  logic [W_S-1:0]   det_s_q, det_s_d;

  int               lim_x, lim_y;
  logic             x_wrap, y_wrap, nxt_found;
  logic [W_S-1:0]   nxt_s;
  logic             start_hs, win_hs, res_hs, done_hs;
  logic             fifo_full, fifo_empty;
  logic [FAW:0]     fifo_count;
  win_pos_t         push_pos, fifo_rdata;
  logic             unused_bits;

  // Per-scale geometry folds to constants; the loops only select by the current scale.
  always_comb begin
    lim_x     = 0;
    lim_y     = 0;
    nxt_found = 1'b0;
    nxt_s     = '0;
    for (int s = 0; s < SCALE_NUM; s++) begin
      if (W_S'(s) == s_q) begin
        lim_x = scaled_dim(IMG_WIDTH, s) - FEATURE_WIDTH;
        lim_y = scaled_dim(IMG_HEIGHT, s) - FEATURE_HEIGHT;
      end
    end
    for (int s = SCALE_NUM - 1; s >= 0; s--) begin
      if ((s > int'(s_q)) && scale_valid(IMG_WIDTH, IMG_HEIGHT, FEATURE_WIDTH, FEATURE_HEIGHT, s)) begin
        nxt_found = 1'b1;
        nxt_s     = W_S'(s);
      end
    end
  end

  assign x_wrap = (int'(x_q) + STEP) > lim_x;
  assign y_wrap = (int'(y_q) + STEP) > lim_y;

  assign start_hs = start_valid_i && start_ready_o;
  assign win_hs   = win_valid_o && win_ready_i;
  assign res_hs   = result_valid_i && result_ready_o;
  assign done_hs  = done_valid_o && done_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_hs) state_d = SCAN;
      SCAN:    if (!ANY_VALID || (win_hs && win_last_o)) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !det_valid_q) state_d = DONE;
      DONE:    if (done_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready_o = (state_q == IDLE);
    win_valid_o   = (state_q == SCAN) && ANY_VALID && !fifo_full;
    win_last_o    = (state_q == SCAN) && ANY_VALID && x_wrap && y_wrap && !nxt_found;
    done_valid_o  = (state_q == DONE);
  end

  // Raster order within a scale, then on to the next scale that can hold a window.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    s_d = s_q;
    if (start_hs) begin
      x_d = '0;
      y_d = '0;
      s_d = FIRST_S;
    end else if (win_hs) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d = '0;
          s_d = nxt_found ? nxt_s : '0;
        end else begin
          y_d = y_q + STEP_Y;
        end
      end else begin
        x_d = x_q + STEP_X;
      end
    end
  end

  assign result_ready_o = !fifo_empty && !(det_valid_q && !detect_ready_i);

  always_comb begin
    det_valid_d = det_valid_q;
    det_x_d     = det_x_q;
    det_y_d     = det_y_q;
    det_s_d     = det_s_q;
    cnt_d       = cnt_q;
    if (det_valid_q && detect_ready_i) det_valid_d = 1'b0;
    if (res_hs && result_i) begin
      det_valid_d = 1'b1;
      det_x_d     = fifo_rdata.x[W_X-1:0];
      det_y_d     = fifo_rdata.y[W_Y-1:0];
      det_s_d     = fifo_rdata.scale[W_S-1:0];
      cnt_d       = cnt_q + W_CNT'(1);
    end
    if (done_hs) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      det_valid_q <= 1'b0;
      det_x_q     <= '0;
      det_y_q     <= '0;
      det_s_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      det_valid_q <= det_valid_d;
      det_x_q     <= det_x_d;
      det_y_q     <= det_y_d;
      det_s_q     <= det_s_d;
    end
  end

  assign push_pos = '{scale: POS_S_W'(s_q), y: POS_XY_W'(y_q), x: POS_XY_W'(x_q)};

  pos_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_pos_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (win_hs),
    .wdata_i (push_pos),
    .pop_i   (res_hs),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_bits = ^{fifo_count, fifo_rdata};

  assign win_x_o        = x_q;
  assign win_y_o        = y_q;
  assign win_scale_o    = s_q;
  assign detect_valid_o = det_valid_q;
  assign detect_x_o     = det_x_q;
  assign detect_y_o     = det_y_q;
  assign detect_scale_o = det_s_q;
  assign done_count_o   = cnt_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: table-driven frames with random handshakes against a
// position-list reference model, plus directed sequences for stall, back-pressure and reset.
`timescale 1ns/1ps
module tb_scan_scheduler;

  localparam int IMG    = 45;
  localparam int FEAT   = 25;
  localparam int NSCALE = 2;
  localparam int STEPV  = 1;
  localparam int MAXI   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, start_ready, win_valid, win_ready, win_last;
  logic       result_valid, result_ready, result, detect_valid, detect_ready;
  logic       done_valid, done_ready;
  logic [5:0] win_x, win_y, detect_x, detect_y;
  logic [0:0] win_scale, detect_scale;
  logic [9:0] done_count;

  logic       s_start_valid, s_start_ready, s_win_valid, s_win_ready, s_win_last;
  logic       s_result_valid, s_result_ready, s_result, s_detect_valid, s_detect_ready;
  logic       s_done_valid, s_done_ready;
  logic [4:0] s_win_x, s_win_y, s_detect_x, s_detect_y;
  logic [0:0] s_win_scale, s_detect_scale, s_done_count;

  always #5 clk = ~clk;

  scan_scheduler dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .win_valid_o(win_valid), .win_ready_i(win_ready),
    .win_x_o(win_x), .win_y_o(win_y), .win_scale_o(win_scale), .win_last_o(win_last),
    .result_valid_i(result_valid), .result_ready_o(result_ready), .result_i(result),
    .detect_valid_o(detect_valid), .detect_ready_i(detect_ready),
    .detect_x_o(detect_x), .detect_y_o(detect_y), .detect_scale_o(detect_scale),
    .done_valid_o(done_valid), .done_ready_i(done_ready), .done_count_o(done_count)
  );

  scan_scheduler #(.IMG_WIDTH(20), .IMG_HEIGHT(20)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_valid_i(s_start_valid), .start_ready_o(s_start_ready),
    .win_valid_o(s_win_valid), .win_ready_i(s_win_ready),
    .win_x_o(s_win_x), .win_y_o(s_win_y), .win_scale_o(s_win_scale), .win_last_o(s_win_last),
    .result_valid_i(s_result_valid), .result_ready_o(s_result_ready), .result_i(s_result),
    .detect_valid_o(s_detect_valid), .detect_ready_i(s_detect_ready),
    .detect_x_o(s_detect_x), .detect_y_o(s_detect_y), .detect_scale_o(s_detect_scale),
    .done_valid_o(s_done_valid), .done_ready_i(s_done_ready), .done_count_o(s_done_count)
  );

  typedef struct { int x; int y; int s; } pos_t;
  typedef struct { int wr_pct; int rv_pct; int rmode; int dr_pct; int exp_cnt; } frame_vec_t;

  pos_t       exp_win[$];
  pos_t       infl_q[$];
  pos_t       det_q[$];
  int         win_idx, det_cnt, last_cnt;
  bit         scanning, frame_done;
  int         checks = 0;
  int         errors = 0;
  frame_vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference window list, straight from the scaling and stride rules.
  task automatic build_windows();
    int w = IMG;
    int h = IMG;
    exp_win.delete();
    for (int s = 0; s < NSCALE; s++) begin
      if (w >= FEAT && h >= FEAT) begin
        for (int y = 0; y <= h - FEAT; y += STEPV) begin
          for (int x = 0; x <= w - FEAT; x += STEPV) begin
            pos_t p;
            p.x = x; p.y = y; p.s = s;
            exp_win.push_back(p);
          end
        end
      end
      w = (w * 4) / 5;
      h = (h * 4) / 5;
    end
  endtask

  function automatic logic pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic decide(input int rm, input pos_t p);
    case (rm)
      0:       return 1'b0;
      1:       return $urandom_range(0, 1) == 1;
      2:       return (p.x == 3 && p.y == 5 && p.s == 0) || (p.x == 0 && p.y == 0 && p.s == 1);
      default: return 1'b1;
    endcase
  endfunction

  task automatic start_frame();
    @(negedge clk);
    start_valid = 1'b1; win_ready = 1'b0; result_valid = 1'b0; result = 1'b0;
    detect_ready = 1'b1; done_ready = 1'b1;
    #1;
    chk("start_ready", start_ready, 1);
    chk("idle_win_valid", win_valid, 0);
    win_idx = 0; det_cnt = 0; infl_q.delete(); det_q.delete();
    scanning = 1'b1; frame_done = 1'b0;
  endtask

  task automatic step(input int wr, input int rv, input int rm, input int dr);
    bit busy;
    @(negedge clk);
    start_valid  = 1'b0;
    done_ready   = 1'b1;
    win_ready    = pct(wr);
    result_valid = pct(rv);
    detect_ready = pct(dr);
    result       = (infl_q.size() > 0) ? decide(rm, infl_q[0]) : 1'b0;
    #1;
    busy = (win_idx < exp_win.size()) || (infl_q.size() > 0) || (det_q.size() > 0);
    chk("win_valid", win_valid, scanning && (win_idx < exp_win.size()) && (infl_q.size() < MAXI));
    chk("result_ready", result_ready, (infl_q.size() > 0) && !((det_q.size() > 0) && !detect_ready));
    chk("detect_valid", detect_valid, det_q.size() > 0);
    if (detect_valid && det_q.size() > 0) begin
      chk("detect_x", detect_x, det_q[0].x);
      chk("detect_y", detect_y, det_q[0].y);
      chk("detect_scale", detect_scale, det_q[0].s);
    end
    if (done_valid) chk("done_premature", busy, 0);
    if (win_valid && win_ready) begin
      if (win_idx < exp_win.size()) begin
        chk("win_x", win_x, exp_win[win_idx].x);
        chk("win_y", win_y, exp_win[win_idx].y);
        chk("win_scale", win_scale, exp_win[win_idx].s);
        chk("win_last", win_last, win_idx == exp_win.size() - 1);
        infl_q.push_back(exp_win[win_idx]);
        win_idx++;
      end else begin
        chk("win_extra", win_idx, exp_win.size() - 1);
      end
    end
    if (detect_valid && detect_ready && det_q.size() > 0) void'(det_q.pop_front());
    if (result_valid && result_ready) begin
      if (infl_q.size() > 0) begin
        pos_t p;
        p = infl_q.pop_front();
        if (result) begin
          det_q.push_back(p);
          det_cnt++;
        end
      end else begin
        chk("result_on_empty", infl_q.size(), 1);
      end
    end
    if (done_valid && done_ready) begin
      chk("done_count", done_count, det_cnt);
      last_cnt   = done_count;
      frame_done = 1'b1;
      scanning   = 1'b0;
    end
  endtask

  task automatic finish_frame(input int wr, input int rv, input int rm, input int dr);
    int n = 0;
    while (!frame_done && n < 20000) begin
      step(wr, rv, rm, dr);
      n++;
    end
    chk("frame_completed", frame_done, 1);
    chk("frame_windows", win_idx, exp_win.size());
  endtask

  task automatic check_reset_state();
    chk("rst_start_ready", start_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_result_ready", result_ready, 0);
    chk("rst_detect_valid", detect_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_win_pos", {win_x, win_y, win_scale}, 0);
    chk("rst_detect_pos", {detect_x, detect_y, detect_scale}, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_small_start_ready", s_start_ready, 1);
    chk("rst_small_win_valid", s_win_valid, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got, win_seen;
    rst_n = 1'b0;
    start_valid = 0; win_ready = 0; result_valid = 0; result = 0; detect_ready = 1; done_ready = 0;
    s_start_valid = 0; s_win_ready = 1; s_result_valid = 0; s_result = 0; s_detect_ready = 1;
    s_done_ready = 0;
    scanning = 0; frame_done = 0; win_idx = 0; det_cnt = 0; last_cnt = 0;
    build_windows();
    vecs[0] = '{100, 100, 0, 100, 0};
    vecs[1] = '{100, 100, 2, 100, 2};
    vecs[2] = '{60,  50,  1, 70,  -1};
    vecs[3] = '{100, 30,  1, 20,  -1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset_state();

    for (int i = 0; i < 4; i++) begin
      start_frame();
      finish_frame(vecs[i].wr_pct, vecs[i].rv_pct, vecs[i].rmode, vecs[i].dr_pct);
      if (vecs[i].exp_cnt >= 0) chk("table_done_count", last_cnt, vecs[i].exp_cnt);
    end

    // Withheld verdicts: issue stalls at the in-flight limit, one verdict reopens it.
    start_frame();
    repeat (6) step(100, 0, 0, 100);
    chk("withheld_issued", win_idx, MAXI);
    chk("withheld_stall", win_valid, 0);
    step(100, 100, 0, 100);
    chk("withheld_still_stalled", win_valid, 0);
    step(100, 0, 0, 100);
    chk("reissue_valid", win_valid, 1);
    chk("reissue_count", win_idx, MAXI + 1);
    finish_frame(80, 60, 1, 80);

    // Detection back-pressure with every verdict positive.
    start_frame();
    repeat (10) step(100, 100, 3, 0);
    chk("hold_accepted", det_cnt, 1);
    chk("hold_result_ready", result_ready, 0);
    chk("hold_detect_valid", detect_valid, 1);
    finish_frame(100, 80, 1, 70);

    // Asynchronous reset mid-scan, then a clean frame.
    start_frame();
    repeat (30) step(100, 50, 3, 50);
    #1 rst_n = 1'b0;
    #1;
    chk("async_win_valid", win_valid, 0);
    chk("async_detect_valid", detect_valid, 0);
    chk("async_result_ready", result_ready, 0);
    chk("async_done_valid", done_valid, 0);
    infl_q.delete(); det_q.delete(); scanning = 0; win_idx = 0; det_cnt = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset_state();
    start_frame();
    finish_frame(70, 70, 1, 60);

    // Image too small for any scale: straight to completion with zero detections.
    @(negedge clk);
    s_start_valid = 1'b1;
    #1 chk("small_start_ready", s_start_ready, 1);
    got = 0; win_seen = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      s_start_valid = 1'b0;
      #1;
      if (s_win_valid) win_seen = 1;
      if (s_done_valid) got = 1;
    end
    chk("small_done_valid", got, 1);
    chk("small_win_issued", win_seen, 0);
    chk("small_done_count", s_done_count, 0);
    s_done_ready = 1'b1;
    @(negedge clk); #1;
    chk("small_back_idle", s_start_ready, 1);
    chk("small_done_cleared", s_done_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
